m_uart_master: RTL and testbench

UART transmitter: accepts parallel words from the MPU-side bus into a small FIFO and serialises them onto `TXD` as 8N1 frames at `BAUD_RATE`. It sits directly upstream of the team's UART receiver and drives its `RXD` line. It uses the same framing, bit order and divisor parameters, so a loopback of the two blocks recovers every written word.

---
 rtl/m_uart_pkg.sv | 16 +
 rtl/m_uart_fifo.sv | 59 +++++
 rtl/m_uart_master.sv | 121 ++++++++++++
 tb/tb_m_uart_master.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/m_uart_pkg.sv
// Shared UART definitions: FSM state encodings and baud divisor computation.
package m_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_e;

  function automatic int unsigned calc_divisor(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/m_uart_fifo.sv
// Synchronous transmit FIFO with registered full/empty flags.
module m_uart_fifo #(
  parameter int unsigned WORD  = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [WORD-1:0] wdata_i,
  output logic [WORD-1:0] rdata_o,
  output logic            full_o,
  output logic            empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WORD-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full_q, empty_q;
  logic            do_push, do_pop;

  // A push into a full FIFO is only accepted when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_q;
  assign do_push = push_i && (!full_q || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == FULL_CNT);
      empty_q <= (cnt_d == '0);
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/m_uart_master.sv
// UART 8N1 transmitter, MSB first, fed from a small FIFO; back-to-back frames have no gap.
module m_uart_master
  import m_uart_pkg::*;
#(
  parameter int unsigned WORD       = 8,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned CLK_FREQ   = 16_000_000,
  parameter int unsigned DIV_BOC    = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WORD-1:0] data_i,
  input  logic            write,
  output logic            TXD,
  output logic [1:0]      state,
  output logic            full,
  output logic            empty,
  output logic            busy,
  output logic            done,
  output logic            overflow
);
  localparam int unsigned DIVISOR = calc_divisor(CLK_FREQ, BAUD_RATE);
  localparam logic [DIV_BOC-1:0] DIV_LAST = DIV_BOC'(DIVISOR - 1);
  localparam int unsigned BW = $clog2(WORD);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD - 1);

  state_e           state_q, state_d;
  logic [DIV_BOC-1:0] div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WORD-1:0]  shift_q, shift_d;
  logic             overflow_q, overflow_d;
  logic             pop, tick;
  logic [WORD-1:0]  fifo_rdata;

  m_uart_fifo #(
    .WORD  (WORD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (write),
    .pop_i   (pop),
    .wdata_i (data_i),
    .rdata_o (fifo_rdata),
    .full_o  (full),
    .empty_o (empty)
  );

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    done    = 1'b0;
    if (state_q != IDLE) div_d = tick ? '0 : div_q + 1'b1;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        shift_d = fifo_rdata;
        div_d   = '0;
        state_d = START;
      end
      START: if (tick) begin
        bit_d   = '0;
        state_d = DATA;
      end
      DATA: if (tick) begin
        shift_d = {shift_q[WORD-2:0], 1'b0};
        if (bit_q == BIT_LAST) state_d = STOP;
        else                   bit_d   = bit_q + 1'b1;
      end
      STOP: if (tick) begin
        done = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    TXD = 1'b1;
    case (state_q)
      START:   TXD = 1'b0;
      DATA:    TXD = shift_q[WORD-1];
      default: TXD = 1'b1;
    endcase
  end

  assign overflow_d = overflow_q | (write & full & ~pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
    end
  end

  assign state    = state_q;
  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_m_uart_master.sv
// Scoreboard bench: stimulus queues expected words, a line-decoding monitor checks each frame.
module tb_m_uart_master;
  localparam int unsigned DIV   = 138;
  localparam int unsigned FRAME = 1380;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       write = 1'b0;
  logic [7:0] data_i = '0;
  logic       TXD, full, empty, busy, done, overflow;
  logic [1:0] state;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_q[$];
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned done_time[$];

  m_uart_master #(
    .WORD       (8),
    .BAUD_RATE  (115200),
    .CLK_FREQ   (16_000_000),
    .DIV_BOC    (12),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_i   (data_i),
    .write    (write),
    .TXD      (TXD),
    .state    (state),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_time.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: decodes the serial line at mid-bit and compares against the scoreboard.
  initial begin : monitor
    logic        prev;
    bit          in_f;
    int unsigned cnt, idx;
    logic [7:0]  rx;
    prev = 1'b1; in_f = 1'b0; cnt = 0; rx = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_f = 1'b0;
        prev = 1'b1;
        continue;
      end
      if (!in_f && prev && !TXD) begin
        in_f = 1'b1;
        cnt  = 0;
      end
      if (in_f) begin
        cnt++;
        if ((cnt - 1) % DIV == DIV / 2) begin
          idx = (cnt - 1) / DIV;
          if (idx == 0)      check("start_bit", {31'd0, TXD}, 32'd0);
          else if (idx <= 8) rx = {rx[6:0], TXD};
          else               check("stop_bit", {31'd0, TXD}, 32'd1);
        end
        if (cnt == FRAME) begin
          check("done_at_frame_end", {31'd0, done}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %0h expected none", rx);
          end else begin
            check("rx_word", {24'd0, rx}, {24'd0, exp_q.pop_front()});
          end
          in_f = 1'b0;
        end else if (done) begin
          check("done_mid_frame", {31'd0, done}, 32'd0);
        end
      end else if (done) begin
        check("done_while_idle", {31'd0, done}, 32'd0);
      end
      prev = TXD;
    end
  end

  task automatic send(input logic [7:0] d, input bit acc);
    data_i = d;
    write  = 1'b1;
    if (acc) exp_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && state == 2'b00 && empty) break;
      @(negedge clk);
    end
    check(name, {31'd0, (exp_q.size() == 0 && state == 2'b00 && empty)}, 32'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned d0, n0, t0, g;
    logic [7:0] rw;

    repeat (3) @(negedge clk);
    check("rst_txd",      {31'd0, TXD},      32'd1);
    check("rst_state",    {30'd0, state},    32'd0);
    check("rst_full",     {31'd0, full},     32'd0);
    check("rst_empty",    {31'd0, empty},    32'd1);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0;

    d0 = done_cnt;
    repeat (2000) @(negedge clk);
    check("idle_no_done", done_cnt - d0, 32'd0);
    check("idle_txd",     {31'd0, TXD}, 32'd1);

    // Single word 0xA5: line should carry 0,1,0,1,0,0,1,0,1,1
    d0 = done_cnt; n0 = done_time.size();
    send(8'hA5, 1'b1);
    write = 1'b0;
    check("a5_txd_after_e0",   {31'd0, TXD},   32'd1);
    check("a5_state_after_e0", {30'd0, state}, 32'd0);
    check("a5_empty_after_e0", {31'd0, empty}, 32'd0);
    @(negedge clk);
    t0 = cyc;
    check("a5_txd_after_e1",   {31'd0, TXD},   32'd0);
    check("a5_state_after_e1", {30'd0, state}, 32'd1);
    check("a5_empty_after_e1", {31'd0, empty}, 32'd1);
    wait_drain("a5_drain", FRAME + 50);
    check("a5_done_count", done_cnt - d0, 32'd1);
    check("a5_done_time", done_time[n0] - t0, FRAME - 1);

    // Three back-to-back words: frames contiguous
    d0 = done_cnt; n0 = done_time.size();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    send(8'h3C, 1'b1);
    write = 1'b0;
    wait_drain("b2b_drain", 4 * FRAME);
    check("b2b_done_count", done_cnt - d0, 32'd3);
    check("b2b_gap1", done_time[n0 + 1] - done_time[n0], FRAME);
    check("b2b_gap2", done_time[n0 + 2] - done_time[n0 + 1], FRAME);

    // Six words into an idle transmitter: the sixth is dropped
    d0 = done_cnt;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    send(8'h44, 1'b1);
    send(8'h55, 1'b1);
    send(8'h66, 1'b0);
    write = 1'b0;
    check("ovf_full",     {31'd0, full},     32'd1);
    check("ovf_overflow", {31'd0, overflow}, 32'd1);
    wait_drain("ovf_drain", 6 * FRAME);
    check("ovf_done_count", done_cnt - d0, 32'd5);
    check("ovf_sticky",     {31'd0, overflow}, 32'd1);

    // Reset during DATA bit 3
    send(8'hC3, 1'b1);
    send(8'h99, 1'b1);
    write = 1'b0;
    repeat (600) @(negedge clk);
    check("mid_state_data", {30'd0, state}, 32'd2);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_txd",      {31'd0, TXD},      32'd1);
    check("mid_rst_state",    {30'd0, state},    32'd0);
    check("mid_rst_empty",    {31'd0, empty},    32'd1);
    check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    d0 = done_cnt;
    send(8'h5A, 1'b1);
    write = 1'b0;
    wait_drain("post_rst_drain", FRAME + 50);
    check("post_rst_done_count", done_cnt - d0, 32'd1);

    // Loopback of 16 random words, writing only when there is room
    for (int unsigned i = 0; i < 16; i++) begin
      g = 0;
      while (full && g < 5000) begin
        write = 1'b0;
        @(negedge clk);
        g++;
      end
      rw = 8'($urandom);
      send(rw, 1'b1);
    end
    write = 1'b0;
    wait_drain("rand_drain", 20 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
